// File: rtl/alu_pkg.sv
// Shared ALU op-code constants and FSM state type, imported by the ALU control
// decoder and by exec_alu_mc.
package alu_pkg;

   localparam logic [3:0] AND_OP   = 4'd0;
   localparam logic [3:0] OR_OP    = 4'd1;
   localparam logic [3:0] ADD_OP   = 4'd2;
   localparam logic [3:0] SLL_OP   = 4'd3;
   localparam logic [3:0] SRL_OP   = 4'd4;
   localparam logic [3:0] SUB_OP   = 4'd6;
   localparam logic [3:0] SLT_OP   = 4'd7;
   localparam logic [3:0] MUL_OP   = 4'd8;
   localparam logic [3:0] VHSUM_OP = 4'd9;

   typedef enum logic {
      IDLE = 1'b0,
      MULT = 1'b1
   } alu_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier consuming K multiplier bits per step.
// With MUL_EARLY_EXIT_EN defined, done also fires once the remaining multiplier bits are zero.
module mul_iter #(
   parameter int DATA_W = 32,
   parameter int K      = 1
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              start_i,
   input  logic              step_i,
   input  logic [DATA_W-1:0] mcand_i,
   input  logic [DATA_W-1:0] mplier_i,
   output logic              done_o,
   output logic [DATA_W-1:0] product_o
);

   localparam int ITER  = DATA_W / K;
   localparam int CNT_W = $clog2(ITER + 1);

   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] partial;
   logic              last_iter;

   // Only the low DATA_W product bits are kept, so the multiplicand is truncated as it shifts.
   assign partial   = mcand_q * DATA_W'(mplier_q[K-1:0]);
   assign last_iter = (cnt_q == CNT_W'(ITER - 1));
   assign product_o = acc_q + partial;

`ifdef MUL_EARLY_EXIT_EN
   assign done_o = step_i & (last_iter | ((mplier_q >> K) == '0));
`else
   assign done_o = step_i & last_iter;
`endif

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         mcand_d  = mcand_i;
         mplier_d = mplier_i;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step_i) begin
         mcand_d  = mcand_q << K;
         mplier_d = mplier_q >> K;
         acc_d    = acc_q + partial;
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/exec_alu_mc.sv
// Execute-stage ALU: registered single-cycle ops plus a multi-cycle MUL that stalls in_ready.
// Optional macro MUL_EARLY_EXIT_EN (in mul_iter) shortens MUL when multiplier bits run out.
module exec_alu_mc
   import alu_pkg::*;
#(
   parameter int DATA_W             = 32,
   parameter int MUL_BITS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        alu_control,
   input  logic [DATA_W-1:0] alu_in_0,
   input  logic [DATA_W-1:0] alu_in_1,
   output logic              out_valid,
   output logic [DATA_W-1:0] alu_out,
   output logic              zero_flag
);

   localparam int SH_W   = $clog2(DATA_W);
   localparam int HALF_W = DATA_W / 2;

   alu_state_e        state_q, state_d;
   logic [DATA_W-1:0] alu_out_q, alu_out_d;
   logic              out_valid_q, out_valid_d;
   logic              zero_q, zero_d;
   logic [DATA_W-1:0] comb_result;
   logic [DATA_W-1:0] mul_result;
   logic              accept, mul_start, mul_step, mul_done;

   assign in_ready  = (state_q == IDLE);
   assign accept    = in_valid & in_ready & ~flush;
   assign mul_start = accept & (alu_control == MUL_OP);
   assign mul_step  = (state_q == MULT) & ~flush;

   mul_iter #(
      .DATA_W (DATA_W),
      .K      (MUL_BITS_PER_CYCLE)
   ) u_mul_iter (
      .clk_i     (clk),
      .arst_i    (arst),
      .start_i   (mul_start),
      .step_i    (mul_step),
      .mcand_i   (alu_in_0),
      .mplier_i  (alu_in_1),
      .done_o    (mul_done),
      .product_o (mul_result)
   );

   always_comb begin
      comb_result = '0;
      case (alu_control)
         AND_OP:   comb_result = alu_in_0 & alu_in_1;
         OR_OP:    comb_result = alu_in_0 | alu_in_1;
         ADD_OP:   comb_result = alu_in_0 + alu_in_1;
         SUB_OP:   comb_result = alu_in_0 - alu_in_1;
         SLL_OP:   comb_result = alu_in_0 << alu_in_1[SH_W-1:0];
         SRL_OP:   comb_result = alu_in_0 >> alu_in_1[SH_W-1:0];
         SLT_OP:   comb_result = {{(DATA_W-1){1'b0}}, ($signed(alu_in_0) < $signed(alu_in_1))};
         // Concatenation keeps each lane sum at HALF_W bits, so lanes wrap independently.
         VHSUM_OP: comb_result = {alu_in_0[DATA_W-1:HALF_W] + alu_in_1[DATA_W-1:HALF_W],
                                  alu_in_0[HALF_W-1:0] + alu_in_1[HALF_W-1:0]};
         default:  comb_result = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = 1'b0;
      alu_out_d   = alu_out_q;
      zero_d      = zero_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (alu_control == MUL_OP) begin
                     state_d = MULT;
                  end else begin
                     out_valid_d = 1'b1;
                     alu_out_d   = comb_result;
                     zero_d      = (comb_result == '0);
                  end
               end
            end
            MULT: begin
               if (mul_done) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b1;
                  alu_out_d   = mul_result;
                  zero_d      = (mul_result == '0);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         alu_out_q   <= '0;
         zero_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         alu_out_q   <= alu_out_d;
         zero_q      <= zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign alu_out   = alu_out_q;
   assign zero_flag = zero_q;

endmodule

// File: tb/tb_exec_alu_mc.sv
// Self-checking bench for exec_alu_mc: directed cases plus randomized ops against a behavioural model.
module tb_exec_alu_mc;

   localparam int DATA_W = 32;
   localparam int K      = 1;
   localparam int ITER   = DATA_W / K;

   logic              clk = 1'b0;
   logic              arst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        alu_control;
   logic [DATA_W-1:0] alu_in_0;
   logic [DATA_W-1:0] alu_in_1;
   logic              out_valid;
   logic [DATA_W-1:0] alu_out;
   logic              zero_flag;

   int checks = 0;
   int passed = 0;

   exec_alu_mc #(
      .DATA_W             (DATA_W),
      .MUL_BITS_PER_CYCLE (K)
   ) dut (
      .clk         (clk),
      .arst        (arst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .alu_in_0    (alu_in_0),
      .alu_in_1    (alu_in_1),
      .out_valid   (out_valid),
      .alu_out     (alu_out),
      .zero_flag   (zero_flag)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [15:0] hi, lo;
      case (op)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd3: return a << b[4:0];
         4'd4: return a >> b[4:0];
         4'd6: return a - b;
         4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8: return a * b;
         4'd9: begin
            hi = a[31:16] + b[31:16];
            lo = a[15:0] + b[15:0];
            return {hi, lo};
         end
         default: return 32'd0;
      endcase
   endfunction

   // Cycles from acceptance to out_valid for a MUL with multiplier b.
   function automatic int mul_latency(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
      int nbits = 0;
      int it;
      for (int i = 0; i < 32; i++) if (b[i]) nbits = i + 1;
      it = (nbits + K - 1) / K;
      if (it == 0) it = 1;
      return it + 1;
`else
      return ITER + 1;
`endif
   endfunction

   task automatic test_reset;
      arst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      alu_control = 4'd0; alu_in_0 = '0; alu_in_1 = '0;
      repeat (2) @(posedge clk);
      #3 arst = 1'b0;
      tick;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
      checks++; if (alu_out !== 32'd0) $display("FAIL reset_alu_out got %h want 0", alu_out); else passed++;
      checks++; if (zero_flag !== 1'b1) $display("FAIL reset_zero got %b want 1", zero_flag); else passed++;
      $display("reset: in_ready=%b out_valid=%b alu_out=%h zero=%b", in_ready, out_valid, alu_out, zero_flag);
   endtask

   task automatic test_add_sub;
      in_valid = 1'b1; alu_control = 4'd2; alu_in_0 = 32'd7; alu_in_1 = 32'd5;
      tick;
      checks++; if (out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", out_valid); else passed++;
      checks++; if (alu_out !== 32'd12) $display("FAIL add_result got %h want 0000000c", alu_out); else passed++;
      checks++; if (zero_flag !== 1'b0) $display("FAIL add_zero got %b want 0", zero_flag); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL add_ready got %b want 1", in_ready); else passed++;
      $display("add 7+5 -> %h valid=%b", alu_out, out_valid);
      alu_control = 4'd6; alu_in_0 = 32'd5; alu_in_1 = 32'd5;
      tick;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) $display("FAIL sub_valid got %b want 1", out_valid); else passed++;
      checks++; if (alu_out !== 32'd0) $display("FAIL sub_result got %h want 0", alu_out); else passed++;
      checks++; if (zero_flag !== 1'b1) $display("FAIL sub_zero got %b want 1", zero_flag); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL sub_ready got %b want 1", in_ready); else passed++;
      $display("sub 5-5 -> %h valid=%b zero=%b", alu_out, out_valid, zero_flag);
      tick;
      checks++; if (out_valid !== 1'b0) $display("FAIL addsub_idle_valid got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_directed;
      logic [3:0]  dop [0:6];
      logic [31:0] da  [0:6];
      logic [31:0] db  [0:6];
      logic [31:0] dexp[0:6];
      dop  = '{4'd9, 4'd7, 4'd4, 4'd5, 4'd3, 4'd0, 4'd1};
      da   = '{32'hFFFF0001, 32'hFFFFFFFF, 32'h80000000, 32'h00001234, 32'h00000001, 32'hF0F0F0F0, 32'hF0F0F0F0};
      db   = '{32'h00010002, 32'h00000001, 32'd31,       32'h00005678, 32'd31,       32'hFF00FF00, 32'h0F0F0F0F};
      dexp = '{32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000, 32'h80000000, 32'hF000F000, 32'hFFFFFFFF};
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; alu_control = dop[i]; alu_in_0 = da[i]; alu_in_1 = db[i];
         tick;
         checks++; if (out_valid !== 1'b1) $display("FAIL directed%0d_valid got %b want 1", i, out_valid); else passed++;
         checks++; if (alu_out !== dexp[i]) $display("FAIL directed%0d_result op=%0d got %h want %h", i, dop[i], alu_out, dexp[i]); else passed++;
         checks++; if (zero_flag !== (dexp[i] == 32'd0)) $display("FAIL directed%0d_zero got %b want %b", i, zero_flag, dexp[i] == 32'd0); else passed++;
         $display("op=%0d a=%h b=%h -> %h", dop[i], da[i], db[i], alu_out);
      end
      in_valid = 1'b0;
      tick;
   endtask

   task automatic test_mul;
      logic [31:0] ma [0:8];
      logic [31:0] mb [0:8];
      logic [31:0] exp_p;
      int          lat;
      ma = '{32'h0000FFFF, 32'h12345678, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      mb = '{32'h00010001, 32'd0,        32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      for (int i = 3; i < 9; i++) begin
         ma[i] = $urandom;
         mb[i] = $urandom >> $urandom_range(0, 31);
      end
      for (int t = 0; t < 9; t++) begin
         exp_p = ref_alu(4'd8, ma[t], mb[t]);
         lat   = mul_latency(mb[t]);
         in_valid = 1'b1; alu_control = 4'd8; alu_in_0 = ma[t]; alu_in_1 = mb[t];
         tick;
         for (int cyc = 1; cyc <= lat; cyc++) begin
            checks++; if (in_ready !== (cyc == lat)) $display("FAIL mul%0d_ready_c%0d got %b want %b", t, cyc, in_ready, cyc == lat); else passed++;
            checks++; if (out_valid !== (cyc == lat)) $display("FAIL mul%0d_valid_c%0d got %b want %b", t, cyc, out_valid, cyc == lat); else passed++;
            if (cyc == lat) begin
               checks++; if (alu_out !== exp_p) $display("FAIL mul%0d_result got %h want %h", t, alu_out, exp_p); else passed++;
               checks++; if (zero_flag !== (exp_p == 32'd0)) $display("FAIL mul%0d_zero got %b want %b", t, zero_flag, exp_p == 32'd0); else passed++;
            end
            // Stalled requests must be ignored while the multiplier is busy.
            in_valid = (cyc < lat) && (cyc <= 3);
            alu_control = 4'd2; alu_in_0 = $urandom; alu_in_1 = $urandom;
            tick;
         end
         in_valid = 1'b0;
         checks++; if (out_valid !== 1'b0) $display("FAIL mul%0d_after_valid got %b want 0", t, out_valid); else passed++;
         $display("mul %h*%h -> %h latency=%0d", ma[t], mb[t], alu_out, lat);
      end
   endtask

   task automatic test_flush;
      int spurious = 0;
      in_valid = 1'b1; alu_control = 4'd2; alu_in_0 = 32'h55; alu_in_1 = 32'h22;
      tick;
      checks++; if (alu_out !== 32'h77) $display("FAIL flush_setup got %h want 00000077", alu_out); else passed++;
      alu_control = 4'd8; alu_in_0 = 32'hDEADBEEF; alu_in_1 = 32'hFFFFFFFF;
      tick;
      in_valid = 1'b0;
      repeat (4) tick;
      checks++; if (in_ready !== 1'b0) $display("FAIL flush_busy_ready got %b want 0", in_ready); else passed++;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      checks++; if (in_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", in_ready); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", out_valid); else passed++;
      checks++; if (alu_out !== 32'h77) $display("FAIL flush_hold got %h want 00000077", alu_out); else passed++;
      for (int c = 0; c < ITER + 4; c++) begin
         if (out_valid !== 1'b0) spurious++;
         tick;
      end
      checks++; if (spurious != 0) $display("FAIL flush_spurious got %0d pulses want 0", spurious); else passed++;
      in_valid = 1'b1; alu_control = 4'd2; alu_in_0 = 32'd1; alu_in_1 = 32'd1; flush = 1'b1;
      tick;
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_accept_valid got %b want 0", out_valid); else passed++;
      checks++; if (alu_out !== 32'h77) $display("FAIL flush_accept_hold got %h want 00000077", alu_out); else passed++;
      alu_in_0 = 32'd3; alu_in_1 = 32'd4;
      tick;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) $display("FAIL flush_next_valid got %b want 1", out_valid); else passed++;
      checks++; if (alu_out !== 32'd7) $display("FAIL flush_next_result got %h want 00000007", alu_out); else passed++;
      $display("flush: alu_out=%h after follow-up add", alu_out);
      tick;
   endtask

   task automatic test_back_to_back;
      logic [31:0] held;
      logic        exp_v;
      logic [3:0]  op;
      logic [31:0] a, b;
      logic        v, fl;
      in_valid = 1'b1; alu_control = 4'd2; alu_in_0 = 32'd0; alu_in_1 = 32'd0;
      tick;
      held = 32'd0;
      for (int i = 0; i < 60; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 7) == 0);
         op = 4'($urandom_range(0, 15));
         if (op == 4'd8) op = 4'd9;
         a = $urandom; b = $urandom;
         in_valid = v; flush = fl; alu_control = op; alu_in_0 = a; alu_in_1 = b;
         tick;
         exp_v = v && !fl;
         if (exp_v) held = ref_alu(op, a, b);
         checks++; if (out_valid !== exp_v) $display("FAIL b2b%0d_valid got %b want %b", i, out_valid, exp_v); else passed++;
         checks++; if (alu_out !== held) $display("FAIL b2b%0d_result op=%0d got %h want %h", i, op, alu_out, held); else passed++;
         checks++; if (zero_flag !== (held == 32'd0)) $display("FAIL b2b%0d_zero got %b want %b", i, zero_flag, held == 32'd0); else passed++;
         checks++; if (in_ready !== 1'b1) $display("FAIL b2b%0d_ready got %b want 1", i, in_ready); else passed++;
         $display("b2b %0d: v=%b fl=%b op=%0d a=%h b=%h -> valid=%b out=%h", i, v, fl, op, a, b, out_valid, alu_out);
      end
      in_valid = 1'b0; flush = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_mul;
      int late = 0;
      in_valid = 1'b1; alu_control = 4'd2; alu_in_0 = 32'd1; alu_in_1 = 32'd1;
      tick;
      checks++; if (alu_out !== 32'd2) $display("FAIL rstmul_setup got %h want 00000002", alu_out); else passed++;
      alu_control = 4'd8; alu_in_0 = $urandom; alu_in_1 = 32'hFFFFFFFF;
      tick;
      in_valid = 1'b0;
      repeat (9) tick;
      checks++; if (in_ready !== 1'b0) $display("FAIL rstmul_busy got %b want 0", in_ready); else passed++;
      #2 arst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL rstmul_async_ready got %b want 1", in_ready); else passed++;
      checks++; if (alu_out !== 32'd0) $display("FAIL rstmul_async_out got %h want 0", alu_out); else passed++;
      @(negedge clk) arst = 1'b0;
      tick;
      checks++; if (in_ready !== 1'b1) $display("FAIL rstmul_ready got %b want 1", in_ready); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL rstmul_valid got %b want 0", out_valid); else passed++;
      checks++; if (alu_out !== 32'd0) $display("FAIL rstmul_out got %h want 0", alu_out); else passed++;
      checks++; if (zero_flag !== 1'b1) $display("FAIL rstmul_zero got %b want 1", zero_flag); else passed++;
      for (int c = 0; c < ITER + 4; c++) begin
         if (out_valid !== 1'b0) late++;
         tick;
      end
      checks++; if (late != 0) $display("FAIL rstmul_late_pulse got %0d want 0", late); else passed++;
      $display("reset mid-mul: in_ready=%b alu_out=%h zero=%b", in_ready, alu_out, zero_flag);
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_directed();
      test_mul();
      test_flush();
      test_back_to_back();
      test_reset_mid_mul();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
